serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be at least 1.
REQ-002 Parameter DIGIT, default 1, bits added per clock; SHALL divide WIDTH exactly; NSTEP = WIDTH/DIGIT.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 start  input  1  request to add the present a, b, cin.
REQ-006 a  input  WIDTH  operand A, sampled only when start is accepted.
REQ-007 b  input  WIDTH  operand B, sampled only when start is accepted.
REQ-008 cin  input  1  carry-in, sampled only when start is accepted.
REQ-009 busy  output  1  high while an addition is in progress (RUN state).
REQ-010 done  output  1  single-cycle pulse; sum, cout and overflow are valid.
REQ-011 sum  output  WIDTH  result a + b + cin, modulo 2^WIDTH.
REQ-012 cout  output  1  unsigned carry out of bit WIDTH-1.
REQ-013 overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE; reset state IDLE.
REQ-015 start SHALL be accepted only in IDLE or DONE; accepting it latches a, b, cin, clears the step counter and enters RUN.
REQ-016 start in RUN SHALL be ignored; operands and progress SHALL be unaffected.
REQ-017 In RUN, each cycle SHALL add the next DIGIT-bit slice (LSB slice first) plus the registered carry, store the slice result and update the carry flip-flop.
REQ-018 After NSTEP RUN cycles the FSM SHALL enter DONE; with start accepted at edge k, done SHALL be high after edge k+NSTEP for exactly one cycle.
REQ-019 DONE SHALL return to IDLE next edge unless start is high, in which case a new RUN begins (back-to-back, no idle cycle).
REQ-020 sum, cout and overflow SHALL hold their final values from DONE until the next accepted start; sum SHALL not show partial results outside RUN.
REQ-021 Step counter SHALL be ceil(log2(NSTEP+1)) bits and SHALL NOT wrap within a run.
REQ-022 WIDTH=DIGIT (NSTEP=1) SHALL be legal: done asserts one cycle after start.

Reset
REQ-023 reset SHALL force IDLE and busy=0, done=0, sum=0, cout=0, overflow=0, internal carry and counter 0.
REQ-024 reset asserted during RUN or DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-025 reset SHALL take priority over a simultaneous start.

Structure
REQ-026 State encodings (IDLE, RUN, DONE) SHALL live in shared package adder_pkg.
REQ-027 The per-slice DIGIT-bit adder SHALL be a sub-module digit_adder (inputs x, y, ci; outputs s, co, c_msb_in), built from the existing 1-bit full adder adder.
REQ-028 Operand storage SHALL be shift registers shifting right by DIGIT per RUN cycle; the result SHALL be assembled by shifting in from the MSB end.

Verification (WIDTH=8 unless stated)
REQ-029 DIGIT=1: start with a=0xFF, b=0x01, cin=0 -> done 8 cycles later, sum=0x00, cout=1, overflow=0.
REQ-030 DIGIT=1: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, overflow=1; then a=0xA5, b=0x5A, cin=1 issued in the DONE cycle -> no idle gap, sum=0x00, cout=1, overflow=0.
REQ-031 start pulsed with a=0x11 three cycles into a run of a=0x03, b=0x04 -> result sum=0x07, done exactly once, at original timing.
REQ-032 reset asserted at RUN step 4 -> all outputs 0 next cycle, no done pulse; subsequent start a=0x10, b=0x20 -> sum=0x30.
REQ-033 DIGIT=4: a=0x99, b=0x99, cin=0 -> done 2 cycles after start, sum=0x32, cout=1, overflow=1.
REQ-034 Exhaustive, WIDTH=4, DIGIT=2: all a, b, cin combinations -> sum, cout, overflow match a reference model; latency 2 each.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder family.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder.sv
// 1-bit full adder, the leaf cell of the digit adder.
module adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/digit_adder.sv
// DIGIT-bit ripple adder; also exposes the carry into its top bit for overflow detection.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  adder u_fa [DIGIT-1:0] (
    .x  (x),
    .y  (y),
    .ci (c[DIGIT-1:0]),
    .s  (s),
    .co (c[DIGIT:1])
  );

  assign co       = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit sum computed DIGIT bits per clock, LSB slice first.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NSTEP = WIDTH / DIGIT;
  localparam int CW    = $clog2(NSTEP + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0] dsum;
  logic             dco;
  logic             dcmsb;
  logic             last;

  digit_adder #(.DIGIT(DIGIT)) u_dig (
    .x        (a_q[DIGIT-1:0]),
    .y        (b_q[DIGIT-1:0]),
    .ci       (carry_q),
    .s        (dsum),
    .co       (dco),
    .c_msb_in (dcmsb)
  );

  assign last = (cnt_q == CW'(NSTEP - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          acc_d   = '0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        // Slice results enter at the MSB end so the last slice lands in place.
        acc_d   = (acc_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
        carry_d = dco;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          sum_d   = acc_d;
          cout_d  = dco;
          ovf_d   = dco ^ dcmsb;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for three serial_adder configurations: 8/1, 8/4 and 4/2.
module tb_serial_adder;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       v;
    longint     due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       st [3];
  logic       rs [3];
  logic       ci [3];
  logic [7:0] av [2];
  logic [7:0] bv [2];
  logic [3:0] a2, b2;
  logic       bz [3];
  logic       dn [3];
  logic       co [3];
  logic       ov [3];
  logic [7:0] sm [3];
  logic [3:0] sm2;

  assign sm[2] = {4'h0, sm2};

  int W  [3] = '{8, 8, 4};
  int NS [3] = '{8, 2, 2};

  exp_t   q0[$], q1[$], q2[$];
  int     vectors = 0;
  int     miscompares = 0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .reset(rs[0]), .start(st[0]), .a(av[0]), .b(bv[0]), .cin(ci[0]),
    .busy(bz[0]), .done(dn[0]), .sum(sm[0]), .cout(co[0]), .overflow(ov[0]));

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .reset(rs[1]), .start(st[1]), .a(av[1]), .b(bv[1]), .cin(ci[1]),
    .busy(bz[1]), .done(dn[1]), .sum(sm[1]), .cout(co[1]), .overflow(ov[1]));

  serial_adder #(.WIDTH(4), .DIGIT(2)) u_w4 (
    .clk(clk), .reset(rs[2]), .start(st[2]), .a(a2), .b(b2), .cin(ci[2]),
    .busy(bz[2]), .done(dn[2]), .sum(sm2), .cout(co[2]), .overflow(ov[2]));

  // Reference: plain integer addition, signed overflow from operand/result sign bits.
  function automatic exp_t model(int w, int a, int b, int cin, longint due);
    exp_t e;
    int tot, sa, sb, ss;
    tot   = a + b + cin;
    e.s   = 8'(tot & ((1 << w) - 1));
    e.c   = ((tot >> w) & 1) != 0;
    sa    = (a >> (w - 1)) & 1;
    sb    = (b >> (w - 1)) & 1;
    ss    = (tot >> (w - 1)) & 1;
    e.v   = (sa == sb) && (ss != sa);
    e.due = due;
    return e;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int qsize(int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push(int d, exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop(int d, output exp_t e, output bit ok);
    ok = (qsize(d) != 0);
    e  = '{8'h0, 1'b0, 1'b0, 0};
    if (ok) begin
      case (d)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (dn[d] === 1'b1) begin
        exp_t e;
        bit   ok;
        pop(d, e, ok);
        if (!ok) begin
          vectors++;
          miscompares++;
          $display("FAIL dut%0d spurious done at cycle %0d", d, cyc);
        end else begin
          chk($sformatf("dut%0d sum", d), 64'(sm[d]), 64'(e.s));
          chk($sformatf("dut%0d cout", d), 64'(co[d]), 64'(e.c));
          chk($sformatf("dut%0d overflow", d), 64'(ov[d]), 64'(e.v));
          chk($sformatf("dut%0d done cycle", d), 64'(cyc), 64'(e.due));
          chk($sformatf("dut%0d busy at done", d), 64'(bz[d]), 64'(0));
        end
      end
    end
  end

  // Called at a negedge; start is held through exactly one rising edge.
  task automatic issue(int d, int a, int b, int cin, bit accept);
    if (d == 2) begin
      a2 = 4'(a);
      b2 = 4'(b);
    end else begin
      av[d] = 8'(a);
      bv[d] = 8'(b);
    end
    ci[d] = cin[0];
    st[d] = 1'b1;
    if (accept) push(d, model(W[d], a, b, cin, cyc + 1 + longint'(NS[d])));
    @(negedge clk);
    st[d] = 1'b0;
  endtask

  task automatic wait_done(int d);
    int n = 0;
    while (dn[d] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL dut%0d timeout waiting for done", d);
    end
  endtask

  task automatic check_zero(int d, string tag);
    chk($sformatf("dut%0d %s busy", d, tag), 64'(bz[d]), 64'(0));
    chk($sformatf("dut%0d %s done", d, tag), 64'(dn[d]), 64'(0));
    chk($sformatf("dut%0d %s sum", d, tag), 64'(sm[d]), 64'(0));
    chk($sformatf("dut%0d %s cout", d, tag), 64'(co[d]), 64'(0));
    chk($sformatf("dut%0d %s overflow", d, tag), 64'(ov[d]), 64'(0));
  endtask

  task automatic run_rand(int d, int n);
    int m = (1 << W[d]) - 1;
    for (int i = 0; i < n; i++) begin
      issue(d, int'($urandom) & m, int'($urandom) & m, int'($urandom_range(1, 0)), 1'b1);
      wait_done(d);
      if ($urandom_range(1, 0) == 1) repeat ($urandom_range(3, 1)) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rs[d] = 1'b1;
      st[d] = 1'b0;
      ci[d] = 1'b0;
    end
    av[0] = '0; av[1] = '0; bv[0] = '0; bv[1] = '0; a2 = '0; b2 = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) check_zero(d, "reset");
    for (int d = 0; d < 3; d++) rs[d] = 1'b0;
    @(negedge clk);

    // Wrap to zero with carry out.
    issue(0, 'hFF, 'h01, 0, 1'b1);
    wait_done(0);
    @(negedge clk);

    // Signed overflow, then a back-to-back start in the DONE cycle.
    issue(0, 'h7F, 'h01, 0, 1'b1);
    wait_done(0);
    issue(0, 'hA5, 'h5A, 1, 1'b1);
    wait_done(0);
    @(negedge clk);

    // A start mid-run must be ignored.
    issue(0, 'h03, 'h04, 0, 1'b1);
    @(negedge clk);
    issue(0, 'h11, 'h00, 0, 1'b0);
    wait_done(0);
    @(negedge clk);

    // Reset mid-run aborts without a done pulse.
    issue(0, 'h55, 'h66, 0, 1'b0);
    repeat (3) @(negedge clk);
    rs[0] = 1'b1;
    @(negedge clk);
    rs[0] = 1'b0;
    check_zero(0, "abort");
    repeat (12) @(negedge clk);
    issue(0, 'h10, 'h20, 0, 1'b1);
    wait_done(0);
    @(negedge clk);

    run_rand(0, 30);

    issue(1, 'h99, 'h99, 0, 1'b1);
    wait_done(1);
    @(negedge clk);
    run_rand(1, 30);

    // Exhaustive 4-bit sweep, each start issued in the previous DONE cycle.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          issue(2, a, b, c, 1'b1);
          wait_done(2);
        end
    repeat (5) @(negedge clk);

    for (int d = 0; d < 3; d++) chk($sformatf("dut%0d outstanding", d), 64'(qsize(d)), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
